// File: rtl/flash_spi_pkg.sv
// flash_spi_pkg: opcodes, status bit indices and FSM states shared by the SPI flash front end
package flash_spi_pkg;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_SE   = 8'h20;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam int ST_WIP = 0;
  localparam int ST_WEL = 1;
  typedef enum logic [2:0] {S_IDLE, S_OPCODE, S_ADDR, S_DOUT, S_IGNORE} state_e;
endpackage

// File: rtl/flash_spi_sync.sv
// flash_spi_sync: STAGES-deep pin synchronizer (clk, rst_n, d in; level q plus one-cycle rise/fall out)
module flash_spi_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic prev_q;
  always_comb sync_d = STAGES'({sync_q, d});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= {STAGES{INIT}};
      prev_q <= INIT;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[STAGES-1];
    end
  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;
endmodule

// File: rtl/flash_spi_responder.sv
// flash_spi_responder: SPI mode-0 flash command front end (SCLK/CS/SI in, SO/SO_OE out, RD_* read and ER_* erase handshakes)
module flash_spi_responder
  import flash_spi_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int SYNC_STAGES = 2,
  parameter int SECTOR_BITS = 12
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              SI,
  output logic              SO,
  output logic              SO_OE,
  output logic              RD_REQ,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [7:0]        RD_DATA,
  output logic              ER_REQ,
  output logic [ADDR_W-1:0] ER_ADDR,
  input  logic              ER_DONE
);
  localparam int CW = $clog2(ADDR_W + 10);
  localparam logic [CW-1:0] OP_LAST   = CW'(7);
  localparam logic [CW-1:0] OP_BITS   = CW'(8);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_W + 7);
  localparam logic [CW-1:0] SE_BITS   = CW'(ADDR_W + 8);
  logic sclk_s, sclk_rise, sclk_fall, cs_s, cs_rise, cs_fall, si_s, si_rise, si_fall;
  logic unused_sync;
  state_e state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] in_sh_q, in_sh_d, op_q, op_d, out_sh_q, out_sh_d, hold_q, hold_d, status;
  logic [ADDR_W-1:0] addr_sh_q, addr_sh_d, rd_addr_q, rd_addr_d, er_addr_q, er_addr_d;
  logic [2:0] out_cnt_q, out_cnt_d;
  logic armed_q, armed_d, first_q, first_d, rd_vld_q, rd_vld_d;
  logic so_q, so_d, so_oe_q, so_oe_d, rd_req_q, rd_req_d, er_req_q, er_req_d;
  logic wip_q, wip_d, wel_q, wel_d;
  flash_spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
    .clk(CLK), .rst_n(RST_N), .d(SCLK), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
  flash_spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
    .clk(CLK), .rst_n(RST_N), .d(CS), .q(cs_s), .rise(cs_rise), .fall(cs_fall));
  flash_spi_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_si (
    .clk(CLK), .rst_n(RST_N), .d(SI), .q(si_s), .rise(si_rise), .fall(si_fall));
  assign unused_sync = ^{sclk_s, si_rise, si_fall};
  always_comb begin
    status         = '0;
    status[ST_WIP] = wip_q;
    status[ST_WEL] = wel_q;
  end
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    in_sh_d   = in_sh_q;
    addr_sh_d = addr_sh_q;
    op_d      = op_q;
    armed_d   = armed_q;
    first_d   = first_q;
    rd_vld_d  = rd_req_q;
    out_sh_d  = out_sh_q;
    hold_d    = hold_q;
    out_cnt_d = out_cnt_q;
    so_d      = so_q;
    so_oe_d   = so_oe_q;
    rd_req_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    er_req_d  = 1'b0;
    er_addr_d = er_addr_q;
    wip_d     = wip_q & ~ER_DONE;
    wel_d     = wel_q;
    // The first returned byte goes straight to the shifter and triggers the prefetch; later ones wait in hold.
    if (rd_vld_q) begin
      if (first_q) begin
        out_sh_d = RD_DATA;
        first_d  = 1'b0;
        if (state_q == S_DOUT) begin
          rd_req_d  = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end else hold_d = RD_DATA;
    end
    if (cs_rise) begin
      if (armed_q && bit_cnt_q == OP_BITS && op_q == OP_WREN) wel_d = 1'b1;
      if (armed_q && bit_cnt_q == OP_BITS && op_q == OP_WRDI) wel_d = 1'b0;
      if (armed_q && bit_cnt_q == SE_BITS && op_q == OP_SE && wel_q) begin
        er_req_d  = 1'b1;
        er_addr_d = {addr_sh_q[ADDR_W-1:SECTOR_BITS], {SECTOR_BITS{1'b0}}};
        wip_d     = 1'b1;
        wel_d     = 1'b0;
      end
      state_d = S_IDLE;
      armed_d = 1'b0;
      first_d = 1'b0;
      so_d    = 1'b0;
      so_oe_d = 1'b0;
    end else if (cs_fall) begin
      state_d   = S_OPCODE;
      bit_cnt_d = '0;
      armed_d   = 1'b0;
      first_d   = 1'b0;
      out_cnt_d = '0;
    end else if (!cs_s && sclk_rise && state_q != S_IDLE) begin
      bit_cnt_d = &bit_cnt_q ? bit_cnt_q : bit_cnt_q + 1'b1;
      in_sh_d   = {in_sh_q[6:0], si_s};
      addr_sh_d = state_q == S_ADDR ? {addr_sh_q[ADDR_W-2:0], si_s} : addr_sh_q;
      if (state_q == S_OPCODE && bit_cnt_q == OP_LAST) begin
        op_d = in_sh_d;
        if (wip_q && in_sh_d != OP_RDSR) state_d = S_IGNORE;
        else if (in_sh_d == OP_READ || in_sh_d == OP_SE) state_d = S_ADDR;
        else if (in_sh_d == OP_RDSR) begin
          state_d  = S_DOUT;
          out_sh_d = status;
        end else begin
          state_d = S_IGNORE;
          armed_d = in_sh_d == OP_WREN || in_sh_d == OP_WRDI;
        end
      end
      if (state_q == S_ADDR && bit_cnt_q == ADDR_LAST) begin
        if (op_q == OP_READ) begin
          state_d   = S_DOUT;
          rd_req_d  = 1'b1;
          rd_addr_d = addr_sh_d;
          first_d   = 1'b1;
        end else begin
          state_d = S_IGNORE;
          armed_d = 1'b1;
        end
      end
    end else if (!cs_s && sclk_fall && state_q == S_DOUT) begin
      so_d      = out_sh_q[7];
      so_oe_d   = 1'b1;
      out_cnt_d = out_cnt_q + 1'b1;
      out_sh_d  = {out_sh_q[6:0], 1'b0};
      if (out_cnt_q == 3'd7) begin
        out_sh_d = op_q == OP_RDSR ? status : hold_q;
        if (op_q == OP_READ) begin
          rd_req_d  = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      in_sh_q   <= '0;
      addr_sh_q <= '0;
      op_q      <= '0;
      armed_q   <= 1'b0;
      first_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      out_sh_q  <= '0;
      hold_q    <= '0;
      out_cnt_q <= '0;
      so_q      <= 1'b0;
      so_oe_q   <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      er_req_q  <= 1'b0;
      er_addr_q <= '0;
      wip_q     <= 1'b0;
      wel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      in_sh_q   <= in_sh_d;
      addr_sh_q <= addr_sh_d;
      op_q      <= op_d;
      armed_q   <= armed_d;
      first_q   <= first_d;
      rd_vld_q  <= rd_vld_d;
      out_sh_q  <= out_sh_d;
      hold_q    <= hold_d;
      out_cnt_q <= out_cnt_d;
      so_q      <= so_d;
      so_oe_q   <= so_oe_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      er_req_q  <= er_req_d;
      er_addr_q <= er_addr_d;
      wip_q     <= wip_d;
      wel_q     <= wel_d;
    end
  assign SO      = so_q;
  assign SO_OE   = so_oe_q;
  assign RD_REQ  = rd_req_q;
  assign RD_ADDR = rd_addr_q;
  assign ER_REQ  = er_req_q;
  assign ER_ADDR = er_addr_q;
endmodule

// File: tb/tb_flash_spi_responder.sv
// tb_flash_spi_responder: directed SPI command bench with array back-end model
module tb_flash_spi_responder;
  localparam int HALF = 50;
  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs = 1'b1, si = 1'b0, er_done = 1'b0;
  logic so, so_oe, rd_req, er_req;
  logic [23:0] rd_addr, er_addr;
  logic [7:0] rd_data = '0;
  logic [23:0] rd_log[$];
  int er_cyc = 0, n_chk = 0, n_pass = 0;
  logic oe_seen;
  logic [31:0] rx;
  flash_spi_responder dut (
    .CLK(clk), .RST_N(rst_n), .SCLK(sclk), .CS(cs), .SI(si), .SO(so), .SO_OE(so_oe),
    .RD_REQ(rd_req), .RD_ADDR(rd_addr), .RD_DATA(rd_data),
    .ER_REQ(er_req), .ER_ADDR(er_addr), .ER_DONE(er_done));
  always #5 clk = ~clk;
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a == 24'h000000 ? 8'hA5 : a == 24'h000001 ? 8'h3C : a == 24'hFFFFFF ? 8'h5A : ~a[7:0];
  endfunction
  always @(posedge clk) begin
    if (rd_req) begin
      rd_data <= mem_byte(rd_addr);
      rd_log.push_back(rd_addr);
    end
    if (er_req) er_cyc <= er_cyc + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h exp %h", tag, got, exp);
  endtask
  task automatic xfer(input logic [31:0] tx, input int n, output logic [31:0] r);
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      si = tx[i];
      #(HALF);
      r[i] = so;
      oe_seen = oe_seen | so_oe;
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
    end
  endtask
  task automatic txn(input logic [31:0] hdr, input int hbits, input int rbits, output logic [31:0] r);
    logic [31:0] d;
    oe_seen = 1'b0;
    cs = 1'b0;
    #(4 * HALF);
    xfer(hdr, hbits, d);
    r = '0;
    if (rbits > 0) xfer(32'h0, rbits, r);
    #(HALF);
    cs = 1'b1;
    si = 1'b0;
    #(4 * HALF);
  endtask
  task automatic rdsr(input string tag, input logic [7:0] exp);
    logic [31:0] r;
    txn(32'h05, 8, 16, r);
    chk(tag, r, {16'h0, exp, exp});
  endtask
  task automatic pulse_done;
    @(negedge clk) er_done = 1'b1;
    @(negedge clk) er_done = 1'b0;
    #(4 * HALF);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    #(4 * HALF);
    chk("rst_so", so, 0);
    chk("rst_oe", so_oe, 0);
    chk("rst_rdreq", rd_req, 0);
    chk("rst_erreq", er_req, 0);
    chk("rst_rdaddr", rd_addr, 0);
    chk("rst_eraddr", er_addr, 0);
    rst_n = 1'b1;
    #(4 * HALF);
    rdsr("rdsr_init", 8'h00);
    txn(32'h06, 8, 0, rx);
    rdsr("rdsr_wel", 8'h02);
    txn(32'h20000000, 32, 0, rx);
    chk("se0_cyc", er_cyc, 1);
    chk("se0_addr", er_addr, 24'h000000);
    rdsr("rdsr_wip", 8'h01);
    rd_log.delete();
    txn(32'h03000000, 32, 8, rx);
    chk("rd_wip_oe", oe_seen, 0);
    chk("rd_wip_req", rd_log.size(), 0);
    pulse_done();
    rdsr("rdsr_done", 8'h00);
    txn(32'h20001234, 32, 0, rx);
    chk("se_nowel_cyc", er_cyc, 1);
    rdsr("rdsr_nowel", 8'h00);
    txn(32'h06, 8, 0, rx);
    txn(32'h20001234, 32, 0, rx);
    chk("se1_cyc", er_cyc, 2);
    chk("se1_addr", er_addr, 24'h001000);
    pulse_done();
    txn(32'h0C, 9, 0, rx);
    rdsr("wren9", 8'h00);
    txn(32'h06, 8, 0, rx);
    txn(32'h20000, 20, 0, rx);
    chk("se20_cyc", er_cyc, 2);
    rdsr("se20_wel", 8'h02);
    txn(32'h04, 8, 0, rx);
    rdsr("wrdi", 8'h00);
    rd_log.delete();
    txn(32'h03000000, 32, 16, rx);
    chk("rd0_data", rx, 32'h0000A53C);
    chk("rd0_oe", oe_seen, 1);
    chk("rd0_oe_off", so_oe, 0);
    chk("rd0_nreq", rd_log.size() >= 2, 1);
    chk("rd0_addr0", rd_log.size() > 0 ? rd_log[0] : 24'hxxxxxx, 24'h000000);
    chk("rd0_addr1", rd_log.size() > 1 ? rd_log[1] : 24'hxxxxxx, 24'h000001);
    rd_log.delete();
    txn(32'h03FFFFFF, 32, 16, rx);
    chk("rdw_data", rx, 32'h00005AA5);
    chk("rdw_addr0", rd_log.size() > 0 ? rd_log[0] : 24'hxxxxxx, 24'hFFFFFF);
    chk("rdw_addr1", rd_log.size() > 1 ? rd_log[1] : 24'hxxxxxx, 24'h000000);
    txn(32'h06, 8, 0, rx);
    rd_log.delete();
    oe_seen = 1'b0;
    cs = 1'b0;
    #(4 * HALF);
    xfer(32'h030000, 24, rx);
    xfer(32'hA, 4, rx);
    rst_n = 1'b0;
    #(2 * HALF);
    chk("mid_so", so, 0);
    chk("mid_oe", so_oe, 0);
    chk("mid_rdaddr", rd_addr, 0);
    chk("mid_eraddr", er_addr, 0);
    cs = 1'b1;
    si = 1'b0;
    #(2 * HALF);
    rst_n = 1'b1;
    #(4 * HALF);
    chk("mid_nreq", rd_log.size(), 0);
    rdsr("mid_rdsr", 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
